// File: rtl/bus_load_decoder.sv
// Write-side bus decoder: loads the bus into the selected datapath register and issues DM write strobes.
// Optional sticky illegal-destination flag is compiled in when BUS_LOAD_ERR_EN is defined.
module bus_load_decoder #(
  parameter int AC_W  = 16,
  parameter int REG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        write_en,
  input  logic              wr_valid,
  input  logic [AC_W-1:0]   bus_in,
  input  logic              inc_pc,
  input  logic              inc_r1,
  input  logic              inc_ri,
  input  logic              clr_ac,
  output logic [REG_W-1:0]  r,
  output logic [REG_W-1:0]  dr,
  output logic [REG_W-1:0]  pc,
  output logic [REG_W-1:0]  r1,
  output logic [REG_W-1:0]  r2,
  output logic [REG_W-1:0]  ri,
  output logic [REG_W-1:0]  rj,
  output logic [REG_W-1:0]  rk,
  output logic [REG_W-1:0]  r3,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [REG_W-1:0]  rc,
  output logic [REG_W-1:0]  rx,
  output logic [AC_W-1:0]   tr,
  output logic [AC_W-1:0]   ac,
  output logic              dm_we,
  output logic [REG_W-1:0]  dm_wdata,
  output logic              wr_err
);

  localparam logic [4:0] CODE_DM = 5'd1;
  localparam logic [4:0] CODE_PC = 5'd2;
  localparam logic [4:0] CODE_DR = 5'd3;
  localparam logic [4:0] CODE_R  = 5'd4;
  localparam logic [4:0] CODE_AC = 5'd5;
  localparam logic [4:0] CODE_TR = 5'd6;
  localparam logic [4:0] CODE_R1 = 5'd7;
  localparam logic [4:0] CODE_R2 = 5'd8;
  localparam logic [4:0] CODE_RI = 5'd9;
  localparam logic [4:0] CODE_RJ = 5'd10;
  localparam logic [4:0] CODE_RK = 5'd11;
  localparam logic [4:0] CODE_R3 = 5'd12;
  localparam logic [4:0] CODE_RA = 5'd13;
  localparam logic [4:0] CODE_RB = 5'd14;
  localparam logic [4:0] CODE_RC = 5'd15;
  localparam logic [4:0] CODE_RX = 5'd16;

  function automatic logic [REG_W-1:0] inc_wrap(input logic [REG_W-1:0] v);
    return v + REG_W'(1);
  endfunction

  function automatic logic [REG_W-1:0] low_part(input logic [AC_W-1:0] v);
    return v[REG_W-1:0];
  endfunction

  // One-hot write select, bit index equals destination code; code 0 never selects.
  logic [16:1] sel_p0;

  always_comb begin
    sel_p0 = '0;
    for (int i = 1; i <= 16; i++) begin
      sel_p0[i] = wr_valid && (write_en == 5'(i));
    end
  end

  logic [REG_W-1:0] bus_lo_p0;
  assign bus_lo_p0 = low_part(bus_in);

  // Stage boundary: every output is registered on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      dr       <= '0;
      r        <= '0;
      ac       <= '0;
      tr       <= '0;
      r1       <= '0;
      r2       <= '0;
      ri       <= '0;
      rj       <= '0;
      rk       <= '0;
      r3       <= '0;
      ra       <= '0;
      rb       <= '0;
      rc       <= '0;
      rx       <= '0;
      dm_we    <= 1'b0;
      dm_wdata <= '0;
    end else begin
      // A bus load wins over the increment of the same register.
      if (sel_p0[CODE_PC])      pc <= bus_lo_p0;
      else if (inc_pc)          pc <= inc_wrap(pc);

      if (sel_p0[CODE_R1])      r1 <= bus_lo_p0;
      else if (inc_r1)          r1 <= inc_wrap(r1);

      if (sel_p0[CODE_RI])      ri <= bus_lo_p0;
      else if (inc_ri)          ri <= inc_wrap(ri);

      // Clearing AC wins over a bus load of AC.
      if (clr_ac)               ac <= '0;
      else if (sel_p0[CODE_AC]) ac <= bus_in;

      if (sel_p0[CODE_TR])      tr <= bus_in;
      if (sel_p0[CODE_DR])      dr <= bus_lo_p0;
      if (sel_p0[CODE_R])       r  <= bus_lo_p0;
      if (sel_p0[CODE_R2])      r2 <= bus_lo_p0;
      if (sel_p0[CODE_RJ])      rj <= bus_lo_p0;
      if (sel_p0[CODE_RK])      rk <= bus_lo_p0;
      if (sel_p0[CODE_R3])      r3 <= bus_lo_p0;
      if (sel_p0[CODE_RA])      ra <= bus_lo_p0;
      if (sel_p0[CODE_RB])      rb <= bus_lo_p0;
      if (sel_p0[CODE_RC])      rc <= bus_lo_p0;
      if (sel_p0[CODE_RX])      rx <= bus_lo_p0;

      dm_we <= sel_p0[CODE_DM];
      if (sel_p0[CODE_DM])      dm_wdata <= bus_lo_p0;
    end
  end

`ifdef BUS_LOAD_ERR_EN
  logic illegal_p0;
  assign illegal_p0 = wr_valid && ((write_en == 5'd0) || (write_en > CODE_RX));

  always_ff @(posedge clk) begin
    if (rst)             wr_err <= 1'b0;
    else if (illegal_p0) wr_err <= 1'b1;
  end
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_load_decoder.sv
// Self-checking bench for bus_load_decoder: directed vector table plus randomized traffic vs an array model.
module tb_bus_load_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  write_en;
  logic        wr_valid;
  logic [15:0] bus_in;
  logic        inc_pc, inc_r1, inc_ri, clr_ac;
  logic [7:0]  r, dr, pc, r1, r2, ri, rj, rk, r3, ra, rb, rc, rx;
  logic [15:0] tr, ac;
  logic        dm_we;
  logic [7:0]  dm_wdata;
  logic        wr_err;

  always #5 clk = ~clk;

  bus_load_decoder dut (
    .clk(clk), .rst(rst), .write_en(write_en), .wr_valid(wr_valid), .bus_in(bus_in),
    .inc_pc(inc_pc), .inc_r1(inc_r1), .inc_ri(inc_ri), .clr_ac(clr_ac),
    .r(r), .dr(dr), .pc(pc), .r1(r1), .r2(r2), .ri(ri), .rj(rj), .rk(rk), .r3(r3),
    .ra(ra), .rb(rb), .rc(rc), .rx(rx), .tr(tr), .ac(ac),
    .dm_we(dm_we), .dm_wdata(dm_wdata), .wr_err(wr_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register file indexed by destination code.
  logic [15:0] m [0:16];
  logic        m_dm_we;
  logic [7:0]  m_dm_wdata;
  logic        m_err;

  function automatic logic [15:0] dut_val(input int code);
    case (code)
      2:  return {8'h00, pc};
      3:  return {8'h00, dr};
      4:  return {8'h00, r};
      5:  return ac;
      6:  return tr;
      7:  return {8'h00, r1};
      8:  return {8'h00, r2};
      9:  return {8'h00, ri};
      10: return {8'h00, rj};
      11: return {8'h00, rk};
      12: return {8'h00, r3};
      13: return {8'h00, ra};
      14: return {8'h00, rb};
      15: return {8'h00, rc};
      16: return {8'h00, rx};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input int code, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s code=%0d got=%h expected=%h t=%0t", name, code, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] nxt [0:16];
    int c;
    if (rst) begin
      for (int i = 0; i <= 16; i++) m[i] = 16'h0000;
      m_dm_we = 1'b0; m_dm_wdata = 8'h00; m_err = 1'b0;
      return;
    end
    for (int i = 0; i <= 16; i++) nxt[i] = m[i];
    if (inc_pc) nxt[2] = (m[2] + 16'd1) % 16'd256;
    if (inc_r1) nxt[7] = (m[7] + 16'd1) % 16'd256;
    if (inc_ri) nxt[9] = (m[9] + 16'd1) % 16'd256;
    m_dm_we = 1'b0;
    c = int'(write_en);
    if (wr_valid) begin
      if (c >= 2 && c <= 16)
        nxt[c] = (c == 5 || c == 6) ? bus_in : (bus_in % 16'd256);
      else if (c == 1) begin
        m_dm_we = 1'b1;
        m_dm_wdata = bus_in[7:0];
      end else begin
`ifdef BUS_LOAD_ERR_EN
        m_err = 1'b1;
`endif
      end
    end
    if (clr_ac) nxt[5] = 16'h0000;
    for (int i = 0; i <= 16; i++) m[i] = nxt[i];
  endtask

  task automatic check_all(input string tag);
    for (int c = 2; c <= 16; c++) check({tag, "_reg"}, c, dut_val(c), m[c]);
    check({tag, "_dm_we"}, 1, {15'h0, dm_we}, {15'h0, m_dm_we});
    check({tag, "_dm_wdata"}, 1, {8'h0, dm_wdata}, {8'h0, m_dm_wdata});
    check({tag, "_wr_err"}, 0, {15'h0, wr_err}, {15'h0, m_err});
  endtask

  // Inputs are already set; clock one edge, advance the model, compare on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic rs, input logic [4:0] we, input logic v, input logic [15:0] b,
                       input logic ipc, input logic ir1, input logic iri, input logic clr);
    rst = rs; write_en = we; wr_valid = v; bus_in = b;
    inc_pc = ipc; inc_r1 = ir1; inc_ri = iri; clr_ac = clr;
  endtask

  typedef struct {
    logic        rs;
    logic [4:0]  we;
    logic        v;
    logic [15:0] b;
    logic        ipc, ir1, iri, clr;
    int          chk;
    logic [15:0] exp;
    logic        exp_we;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rs, input logic [4:0] we, input logic v, input logic [15:0] b,
                              input logic ipc, input logic ir1, input logic iri, input logic clr,
                              input int chk, input logic [15:0] exp, input logic exp_we, input logic [7:0] exp_wd);
    vec_t t;
    t.rs = rs; t.we = we; t.v = v; t.b = b;
    t.ipc = ipc; t.ir1 = ir1; t.iri = iri; t.clr = clr;
    t.chk = chk; t.exp = exp; t.exp_we = exp_we; t.exp_wd = exp_wd;
    return t;
  endfunction

  initial begin
    drive(1'b1, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 16; i++) m[i] = 16'h0000;
    m_dm_we = 1'b0; m_dm_wdata = 8'h00; m_err = 1'b0;

    tbl.push_back(mk(1, 5'd0,  0, 16'h0000, 0, 0, 0, 0, 5, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(1, 5'd0,  0, 16'h0000, 0, 0, 0, 0, 2, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 5'd5,  1, 16'hA5C3, 0, 0, 0, 0, 5, 16'hA5C3, 0, 8'h00));
    tbl.push_back(mk(0, 5'd2,  0, 16'hFFFF, 0, 0, 0, 0, 2, 16'h0000, 0, 8'h00));
    for (int c = 2; c <= 16; c++)
      tbl.push_back(mk(0, 5'(c), 1, 16'h1200 + 16'(c), 0, 0, 0, 0, c,
                       (c == 5 || c == 6) ? 16'h1200 + 16'(c) : 16'(c), 0, 8'h00));
    tbl.push_back(mk(0, 5'd2,  1, 16'h00FF, 0, 0, 0, 0, 2, 16'h00FF, 0, 8'h00));
    tbl.push_back(mk(0, 5'd0,  0, 16'h0000, 1, 0, 0, 0, 2, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 5'd2,  1, 16'h0040, 1, 0, 0, 0, 2, 16'h0040, 0, 8'h00));
    tbl.push_back(mk(0, 5'd5,  1, 16'hFFFF, 0, 1, 1, 1, 5, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 5'd0,  0, 16'h0000, 0, 0, 0, 0, 7, 16'h0008, 0, 8'h00));
    tbl.push_back(mk(0, 5'd0,  0, 16'h0000, 0, 0, 0, 0, 9, 16'h000A, 0, 8'h00));
    tbl.push_back(mk(0, 5'd1,  1, 16'h3377, 0, 0, 0, 0, 6, 16'h1206, 1, 8'h77));
    tbl.push_back(mk(0, 5'd1,  1, 16'h3377, 0, 0, 0, 0, 2, 16'h0040, 1, 8'h77));
    tbl.push_back(mk(1, 5'd1,  1, 16'h3377, 0, 0, 0, 0, 2, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 5'd0,  1, 16'hBEEF, 0, 0, 0, 0, 2, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 5'd20, 1, 16'hBEEF, 0, 0, 0, 0, 5, 16'h0000, 0, 8'h00));

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].we, tbl[i].v, tbl[i].b, tbl[i].ipc, tbl[i].ir1, tbl[i].iri, tbl[i].clr);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d_sel", i), tbl[i].chk, dut_val(tbl[i].chk), tbl[i].exp);
      check($sformatf("vec%0d_dm_we", i), 1, {15'h0, dm_we}, {15'h0, tbl[i].exp_we});
      check($sformatf("vec%0d_dm_wd", i), 1, {8'h0, dm_wdata}, {8'h0, tbl[i].exp_wd});
    end

    // Sticky error flag: holds through idle cycles and legal writes, cleared only by reset.
    drive(0, 5'd3, 1, 16'h0011, 0, 0, 0, 0);
    step("err_hold");
`ifdef BUS_LOAD_ERR_EN
    check("err_sticky", 0, {15'h0, wr_err}, 16'h0001);
`else
    check("err_tied", 0, {15'h0, wr_err}, 16'h0000);
`endif
    drive(1, 5'd0, 1, 16'hBEEF, 0, 0, 0, 0);
    step("err_rst");
    check("err_cleared", 0, {15'h0, wr_err}, 16'h0000);

    // Back-to-back DM writes with distinct data.
    drive(0, 5'd1, 1, 16'h00A1, 0, 0, 0, 0);
    step("dm_b2b0");
    check("dm_b2b0_wd", 1, {8'h0, dm_wdata}, 16'h00A1);
    drive(0, 5'd1, 1, 16'h00B2, 0, 0, 0, 0);
    step("dm_b2b1");
    check("dm_b2b1_wd", 1, {8'h0, dm_wdata}, 16'h00B2);
    drive(0, 5'd0, 0, 16'h0000, 0, 0, 0, 0);
    step("dm_idle");
    check("dm_idle_we", 1, {15'h0, dm_we}, 16'h0000);
    check("dm_idle_wd", 1, {8'h0, dm_wdata}, 16'h00B2);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
            16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
